// File: rtl/axis_cpu_loader_pkg.sv
// Shared definitions for the CPU program loader and the CPU register map.
// Register addresses, section tags, loader states and the latched input beat.
package axis_cpu_loader_pkg;

  localparam int unsigned REG_PROG    = 0;
  localparam int unsigned REG_INST    = 1;
  localparam int unsigned REG_JMP_OFF = 2;
  localparam int unsigned REG_IMM     = 3;

  localparam logic [31:0] PROG_ON_DAT  = 32'h0000_0001;
  localparam logic [31:0] PROG_OFF_DAT = 32'h0000_0000;

  typedef enum logic [1:0] {
    TAG_INST    = 2'd0,
    TAG_JMP_OFF = 2'd1,
    TAG_IMM     = 2'd2,
    TAG_RSVD    = 2'd3
  } tag_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ON_A,
    ST_ON_D,
    ST_GET,
    ST_WR_A,
    ST_WR_D,
    ST_OFF_A,
    ST_OFF_D
  } state_t;

  typedef struct packed {
    logic [31:0] dat;
    tag_t        tag;
    logic        last;
  } beat_t;

  // Reserved tags never reach a write state; PROG is only a safe fallback.
  function automatic int unsigned tag_to_reg(input tag_t tag);
    case (tag)
      TAG_INST:    return REG_INST;
      TAG_JMP_OFF: return REG_JMP_OFF;
      TAG_IMM:     return REG_IMM;
      default:     return REG_PROG;
    endcase
  endfunction

endpackage

// File: rtl/axis_cpu_loader_cmd_flit_fmt.sv
// Builds a command address flit: target id in the top bits, register address in the bottom bits.
// Latency: combinational.
// Backpressure: none, pure formatting.
module cmd_flit_fmt #(
  parameter int CPU_ID_WIDTH   = 12,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic [CPU_ID_WIDTH-1:0]   id,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [31:0]               flit
);

  always_comb begin
    flit                       = '0;
    flit[31 -: CPU_ID_WIDTH]   = id;
    flit[REG_ADDR_WIDTH-1:0]   = reg_addr;
  end

endmodule

// File: rtl/axis_cpu_loader.sv
// Turns an AXI-Stream program image into PROG-on / register-write / PROG-off command flit pairs.
// Latency: first flit 2 cycles after prog_TVALID in IDLE; each word 3 cycles from handshake to next ready.
// Backpressure: command chain has none; the loader paces itself and throttles input via prog_TREADY.
module axis_cpu_loader
  import axis_cpu_loader_pkg::*;
#(
  parameter int CPU_ID_WIDTH   = 12,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CPU_ID_WIDTH-1:0] target_id,
  input  logic [31:0]             prog_TDATA,
  input  logic [1:0]              prog_TUSER,
  input  logic                    prog_TLAST,
  input  logic                    prog_TVALID,
  output logic                    prog_TREADY,
  output logic [31:0]             cmd_out_TDATA,
  output logic                    cmd_out_TVALID,
  output logic                    busy,
  output logic                    done
);

  state_t                    state_q, state_d;
  logic [CPU_ID_WIDTH-1:0]   id_q;
  beat_t                     beat_q;
  logic [REG_ADDR_WIDTH-1:0] fmt_reg;
  logic [31:0]               addr_flit;
  logic [31:0]               flit_d;
  logic                      flit_vld_d;
  logic                      done_pre_q;
  logic                      in_hs;

  assign in_hs = prog_TVALID & prog_TREADY;

  cmd_flit_fmt #(
    .CPU_ID_WIDTH   (CPU_ID_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fmt (
    .id       (id_q),
    .reg_addr (fmt_reg),
    .flit     (addr_flit)
  );

  always_comb begin
    state_d    = state_q;
    flit_vld_d = 1'b0;
    flit_d     = '0;
    fmt_reg    = REG_ADDR_WIDTH'(REG_PROG);
    case (state_q)
      ST_IDLE: begin
        // The starting beat stays on the bus; it is taken later in GET.
        if (prog_TVALID) state_d = ST_ON_A;
      end
      ST_ON_A: begin
        flit_vld_d = 1'b1;
        flit_d     = addr_flit;
        state_d    = ST_ON_D;
      end
      ST_ON_D: begin
        flit_vld_d = 1'b1;
        flit_d     = PROG_ON_DAT;
        state_d    = ST_GET;
      end
      ST_GET: begin
        if (in_hs) begin
          if (tag_t'(prog_TUSER) == TAG_RSVD) state_d = prog_TLAST ? ST_OFF_A : ST_GET;
          else                                state_d = ST_WR_A;
        end
      end
      ST_WR_A: begin
        fmt_reg    = REG_ADDR_WIDTH'(tag_to_reg(beat_q.tag));
        flit_vld_d = 1'b1;
        flit_d     = addr_flit;
        state_d    = ST_WR_D;
      end
      ST_WR_D: begin
        flit_vld_d = 1'b1;
        flit_d     = beat_q.dat;
        state_d    = beat_q.last ? ST_OFF_A : ST_GET;
      end
      ST_OFF_A: begin
        flit_vld_d = 1'b1;
        flit_d     = addr_flit;
        state_d    = ST_OFF_D;
      end
      ST_OFF_D: begin
        flit_vld_d = 1'b1;
        flit_d     = PROG_OFF_DAT;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      id_q           <= '0;
      beat_q         <= '0;
      prog_TREADY    <= 1'b0;
      cmd_out_TDATA  <= '0;
      cmd_out_TVALID <= 1'b0;
      done_pre_q     <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      if (state_q == ST_IDLE && prog_TVALID) id_q <= target_id;
      if (in_hs) beat_q <= '{dat: prog_TDATA, tag: tag_t'(prog_TUSER), last: prog_TLAST};
      prog_TREADY    <= (state_d == ST_GET);
      cmd_out_TDATA  <= flit_d;
      cmd_out_TVALID <= flit_vld_d;
      // done trails the OFF data flit by one cycle; busy covers it.
      done_pre_q     <= (state_q == ST_OFF_D);
      done           <= done_pre_q;
      busy           <= (state_d != ST_IDLE) || (state_q != ST_IDLE) || done_pre_q;
    end
  end

endmodule

// File: doc/axis_cpu_loader.md
# axis_cpu_loader

Command-stream initiator that turns an AXI-Stream program image into the register-write command flits consumed by the CPU register map daisy chain. It sits at the head of the `cmd_in`/`cmd_out` chain. Per image packet it:
- puts the addressed CPU into programming mode;
- streams instruction, jump-offset and immediate words into that CPU;
- releases the CPU from programming mode.

The command chain has no backpressure, so the loader is the only source of pacing.

## Interface
Parameters:
- `CPU_ID_WIDTH`, 12: width of the target CPU address field in the address flit.
- `REG_ADDR_WIDTH`, 4: width of the register address field in the address flit.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `target_id`  in  `CPU_ID_WIDTH`  CPU to program; sampled in IDLE when a packet starts.
- `prog_TDATA`  in  32  program word.
- `prog_TUSER`  in  2  section tag: 0 = instruction, 1 = jump offset, 2 = immediate, 3 = reserved.
- `prog_TLAST`  in  1  last word of the image.
- `prog_TVALID`  in  1  input valid.
- `prog_TREADY`  out  1  input ready.
- `cmd_out_TDATA`  out  32  command flit.
- `cmd_out_TVALID`  out  1  flit valid; no ready exists, so every valid cycle is consumed.
- `busy`  out  1  high from packet start until `done`, inclusive.
- `done`  out  1  one-cycle pulse after the final release flit.

## Operation
Flit format:
- Each command is two consecutive flits.
- Address flit: bits [31:32-`CPU_ID_WIDTH`] = target id; bits [`REG_ADDR_WIDTH`-1:0] = register address; all other bits 0.
- Data flit: 32-bit value. Instruction and jump-offset words are sent unmodified; the receiver uses bits [7:0].

Register addresses (package constants):
- PROG = 0
- INST = 1
- JMP_OFF = 2
- IMM = 3

States:
- IDLE: `prog_TREADY`=0. If `prog_TVALID`, latch `target_id` and go to ON_A. The beat is not consumed here.
- ON_A: emit address flit (PROG); go to ON_D.
- ON_D: emit data flit 0x00000001; go to GET.
- GET: `prog_TREADY`=1. On handshake, latch data, tag and last.
  - Tag 0–2: go to WR_A.
  - Tag 3: the word is dropped with no command. Go to OFF_A if last, else stay in GET.
- WR_A: emit address flit for INST / JMP_OFF / IMM per tag; go to WR_D.
- WR_D: emit the latched word; go to OFF_A if last, else GET.
- OFF_A: emit address flit (PROG); go to OFF_D.
- OFF_D: emit data flit 0x00000000; go to IDLE and pulse `done`.

Other rules:
- Words are forwarded in arrival order, with no reordering by section. The receiver's per-section write pointers restart at 0 on each PROG write.
- `target_id` changes mid-packet are ignored.
- An empty image cannot occur, because TLAST always rides a real beat.

## Timing
- All outputs are registered.
- `cmd_out_TVALID` is high exactly in the cycle after the FSM enters an emitting state. A data flit always directly follows its address flit, with no gap.
- `prog_TVALID` rising in IDLE at cycle t gives: PROG address flit at t+2, data flit at t+3, `prog_TREADY` high at t+3.
- Handshake in GET at cycle t gives: address flit at t+2, data flit at t+3, next `prog_TREADY` at t+3. Sustained throughput is one word per 3 cycles.
- `done` is high for one cycle, in the cycle after the OFF data flit.
- `busy` rises the cycle after leaving IDLE and falls with `done`.
- Reset values: `prog_TREADY`=0, `cmd_out_TVALID`=0, `cmd_out_TDATA`=0, `busy`=0, `done`=0; state IDLE.
- Reset mid-packet: emission stops immediately, and an address flit may be left without its data flit. The target CPU may remain in programming mode. Recovery is to load a new image.

## Structure
- The shared header holds:
  - the register address constants PROG/INST/JMP_OFF/IMM;
  - the section tag encodings;
  - the state encodings.
  The CPU and the loader include the same header.
- Sub-module `cmd_flit_fmt`: pure formatting of the address flit from (id, reg_addr). It is reused by the debug/readback tools.

## Test plan
- Single-word image (word 0x000000AB, tag 0, last) to target 5 → flits 0x00500000, 0x00000001, 0x00500001, 0x000000AB, 0x00500000, 0x00000000 on consecutive valid cycles, followed by `done`.
- Mixed image: inst 0x11, imm 0xDEADBEEF, jmp 0x04 to target 0xFFF → three write commands in input order with register addresses 1, 3, 2, framed by PROG on/off.
- Tag 3 in mid-image → no command for that word; the neighbouring words are emitted normally. Tag 3 on the last beat → PROG off is still sent.
- `prog_TVALID` toggling randomly within a 10-word image → all 10 commands are emitted and no flit pair is split. `prog_TREADY` is never high outside GET.
- `target_id` changed from 1 to 2 mid-packet → all flits still carry id 1. The next packet uses id 2.
- `rst` asserted during WR_D → `cmd_out_TVALID`=0 and `busy`=0 in the next cycle. A new image afterwards programs correctly starting with PROG on.
